// File: rtl/thread_fetch_sched_if.sv
// Fetch-scheduler bus: thread-control events and backpressure in, fetch address pair and
// run mask out. The master side is execute/fetch; the slave side is the scheduler.
interface thread_fetch_sched_if #(
   parameter int unsigned NUM_THREADS = 8,
   parameter int unsigned XLEN        = 32
);
   localparam int unsigned THREAD_WIDTH = $clog2(NUM_THREADS);

   logic                    stall;
   logic                    start_valid;
   logic [THREAD_WIDTH-1:0] start_tid;
   logic [XLEN-1:0]         start_pc;
   logic                    redirect_valid;
   logic [THREAD_WIDTH-1:0] redirect_tid;
   logic [XLEN-1:0]         redirect_pc;
   logic                    block_valid;
   logic [THREAD_WIDTH-1:0] block_tid;
   logic                    wake_valid;
   logic [THREAD_WIDTH-1:0] wake_tid;
   logic                    halt_valid;
   logic [THREAD_WIDTH-1:0] halt_tid;
   logic                    fetch_valid;
   logic [THREAD_WIDTH-1:0] fetch_tid;
   logic [XLEN-1:0]         fetch_pc;
   logic [NUM_THREADS-1:0]  run_mask;

   modport master (
      output stall, start_valid, start_tid, start_pc, redirect_valid, redirect_tid, redirect_pc,
             block_valid, block_tid, wake_valid, wake_tid, halt_valid, halt_tid,
      input  fetch_valid, fetch_tid, fetch_pc, run_mask
   );

   modport slave (
      input  stall, start_valid, start_tid, start_pc, redirect_valid, redirect_tid, redirect_pc,
             block_valid, block_tid, wake_valid, wake_tid, halt_valid, halt_tid,
      output fetch_valid, fetch_tid, fetch_pc, run_mask
   );
endinterface

// File: rtl/thread_fetch_sched.sv
// Barrel fetch scheduler: per-thread PC and run state, one round-robin issue per cycle.
// Define THREAD_SCHED_FIXED_PRIO_EN to replace round-robin with lowest-eligible-tid priority.
module thread_fetch_sched #(
   parameter int unsigned NUM_THREADS = 8,
   parameter int unsigned XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   thread_fetch_sched_if.slave   bus
);
   localparam int unsigned TW = $clog2(NUM_THREADS);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StWait = 2'd2
   } thread_state_e;

   thread_state_e           state_q [NUM_THREADS];
   thread_state_e           state_d [NUM_THREADS];
   logic [XLEN-1:0]         pc_q    [NUM_THREADS];
   logic [XLEN-1:0]         pc_d    [NUM_THREADS];
   logic [TW-1:0]           last_q, last_d;
   logic                    fetch_valid_q, fetch_valid_d;
   logic [TW-1:0]           fetch_tid_q, fetch_tid_d;
   logic [XLEN-1:0]         fetch_pc_q, fetch_pc_d;
   logic [NUM_THREADS-1:0]  run_mask_q, run_mask_d;

   logic [NUM_THREADS-1:0]  eligible;
   logic                    sel_found;
   logic [TW-1:0]           sel_tid;
   logic                    issue;
   logic [XLEN-1:0]         eff_pc;
   logic [XLEN-1:0]         start_pc_al, redirect_pc_al;

   assign start_pc_al    = bus.start_pc & ~XLEN'(3);
   assign redirect_pc_al = bus.redirect_pc & ~XLEN'(3);

   // Threads being halted or blocked this cycle must not issue.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         eligible[i] = (state_q[i] == StRun)
                       && !(bus.halt_valid && bus.halt_tid == TW'(i))
                       && !(bus.block_valid && bus.block_tid == TW'(i));
      end
   end

   // Scan in reverse so the first candidate in priority order is the last one assigned.
   always_comb begin
      sel_found = 1'b0;
      sel_tid   = '0;
`ifdef THREAD_SCHED_FIXED_PRIO_EN
      for (int k = NUM_THREADS - 1; k >= 0; k--) begin
         if (eligible[k]) begin
            sel_found = 1'b1;
            sel_tid   = TW'(k);
         end
      end
`else
      for (int k = NUM_THREADS; k >= 1; k--) begin
         if (eligible[last_q + TW'(k)]) begin
            sel_found = 1'b1;
            sel_tid   = last_q + TW'(k);
         end
      end
`endif
   end

   assign issue  = sel_found && !bus.stall;
   assign eff_pc = (bus.redirect_valid && bus.redirect_tid == sel_tid) ? redirect_pc_al
                                                                       : pc_q[sel_tid];

   always_comb begin
      for (int i = 0; i < NUM_THREADS; i++) begin
         state_d[i] = state_q[i];
         pc_d[i]    = pc_q[i];
         if (bus.start_valid && bus.start_tid == TW'(i) && state_q[i] == StIdle) begin
            state_d[i] = StRun;
            pc_d[i]    = start_pc_al;
         end
         if (bus.wake_valid && bus.wake_tid == TW'(i) && state_q[i] == StWait) begin
            state_d[i] = StRun;
         end
         if (bus.block_valid && bus.block_tid == TW'(i) && state_q[i] == StRun) begin
            state_d[i] = StWait;
         end
         if (bus.halt_valid && bus.halt_tid == TW'(i)) begin
            state_d[i] = StIdle;
         end
         if (bus.redirect_valid && bus.redirect_tid == TW'(i)) begin
            pc_d[i] = redirect_pc_al;
         end
         if (issue && sel_tid == TW'(i)) begin
            pc_d[i] = eff_pc + XLEN'(4);
         end
      end
      run_mask_d = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         run_mask_d[i] = (state_d[i] == StRun);
      end
      fetch_valid_d = bus.stall ? fetch_valid_q : sel_found;
      fetch_tid_d   = issue ? sel_tid : fetch_tid_q;
      fetch_pc_d    = issue ? eff_pc : fetch_pc_q;
      last_d        = issue ? sel_tid : last_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_THREADS; i++) begin
            state_q[i] <= (i == 0) ? StRun : StIdle;
            pc_q[i]    <= RESET_PC;
         end
         last_q        <= TW'(NUM_THREADS - 1);
         fetch_valid_q <= 1'b0;
         fetch_tid_q   <= '0;
         fetch_pc_q    <= '0;
         run_mask_q    <= NUM_THREADS'(1);
      end else begin
         for (int i = 0; i < NUM_THREADS; i++) begin
            state_q[i] <= state_d[i];
            pc_q[i]    <= pc_d[i];
         end
         last_q        <= last_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_tid_q   <= fetch_tid_d;
         fetch_pc_q    <= fetch_pc_d;
         run_mask_q    <= run_mask_d;
      end
   end

   assign bus.fetch_valid = fetch_valid_q;
   assign bus.fetch_tid   = fetch_tid_q;
   assign bus.fetch_pc    = fetch_pc_q;
   assign bus.run_mask    = run_mask_q;
endmodule

// File: tb/tb_thread_fetch_sched.sv
// Randomized bench for thread_fetch_sched with an array-based reference model checked
// every cycle, plus directed sequences with literal expectations.
module tb_thread_fetch_sched;
   localparam int N  = 8;
   localparam int XL = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   thread_fetch_sched_if #(.NUM_THREADS(N), .XLEN(XL)) bus ();

   thread_fetch_sched #(.NUM_THREADS(N), .XLEN(XL), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Model: state 0=IDLE 1=RUN 2=WAIT
   int          m_st [N];
   logic [31:0] m_pc [N];
   int          m_last;
   logic        m_fv;
   int          m_tid;
   logic [31:0] m_fpc;

   int vectors = 0;
   int miscompares = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic bit elig(input int t);
      return m_st[t] == 1 && !(bus.halt_valid && int'(bus.halt_tid) == t)
             && !(bus.block_valid && int'(bus.block_tid) == t);
   endfunction

   always @(posedge clk) begin : model
      int sel;
      int nst [N];
      int t;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_st[i] = (i == 0) ? 1 : 0;
            m_pc[i] = 32'h0;
         end
         m_last = N - 1; m_fv = 1'b0; m_tid = 0; m_fpc = 32'h0;
      end else begin
         sel = -1;
         if (!bus.stall) begin
            for (int k = 1; k <= N; k++) begin
`ifdef THREAD_SCHED_FIXED_PRIO_EN
               t = k - 1;
`else
               t = (m_last + k) % N;
`endif
               if (sel < 0 && elig(t)) sel = t;
            end
         end
         nst = m_st;
         if (bus.start_valid && m_st[bus.start_tid] == 0) begin
            nst[bus.start_tid] = 1;
            m_pc[bus.start_tid] = bus.start_pc & 32'hFFFF_FFFC;
         end
         if (bus.wake_valid && m_st[bus.wake_tid] == 2) nst[bus.wake_tid] = 1;
         if (bus.block_valid && m_st[bus.block_tid] == 1) nst[bus.block_tid] = 2;
         if (bus.halt_valid) nst[bus.halt_tid] = 0;
         // Redirect lands first, so an issue of the same thread reads the new target.
         if (bus.redirect_valid) m_pc[bus.redirect_tid] = bus.redirect_pc & 32'hFFFF_FFFC;
         if (sel >= 0) begin
            m_fv = 1'b1; m_tid = sel; m_fpc = m_pc[sel];
            m_pc[sel] = m_pc[sel] + 32'd4;
            m_last = sel;
         end else if (!bus.stall) begin
            m_fv = 1'b0;
         end
         m_st = nst;
      end
   end

   always @(negedge clk) begin : compare
      logic [31:0] mask;
      if (check_en) begin
         mask = '0;
         for (int i = 0; i < N; i++) mask[i] = (m_st[i] == 1);
         chk("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, m_fv});
         chk("fetch_tid", {29'b0, bus.fetch_tid}, m_tid);
         chk("fetch_pc", bus.fetch_pc, m_fpc);
         chk("run_mask", {24'b0, bus.run_mask}, mask);
      end
   end

   task automatic idle_in();
      bus.stall = 0; bus.start_valid = 0; bus.start_tid = 0; bus.start_pc = 0;
      bus.redirect_valid = 0; bus.redirect_tid = 0; bus.redirect_pc = 0;
      bus.block_valid = 0; bus.block_tid = 0; bus.wake_valid = 0; bus.wake_tid = 0;
      bus.halt_valid = 0; bus.halt_tid = 0;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic exp_issue(input string name, input int tid, input logic [31:0] pc);
      chk({name, ".valid"}, {31'b0, bus.fetch_valid}, 32'd1);
      chk({name, ".tid"}, {29'b0, bus.fetch_tid}, tid);
      chk({name, ".pc"}, bus.fetch_pc, pc);
   endtask

   initial begin
      idle_in();
      rst_n = 1'b0;
      repeat (2) cyc();
      check_en = 1'b1;
      chk("rst_valid", {31'b0, bus.fetch_valid}, 32'd0);
      chk("rst_pc", bus.fetch_pc, 32'h0);
      chk("rst_mask", {24'b0, bus.run_mask}, 32'h01);
      rst_n = 1'b1;
      cyc(); exp_issue("t0a", 0, 32'h0);
      cyc(); exp_issue("t0b", 0, 32'h4);
      cyc(); exp_issue("t0c", 0, 32'h8);
      bus.start_valid = 1; bus.start_tid = 1; bus.start_pc = 32'h100;
      cyc(); exp_issue("st1", 0, 32'hC);
      bus.start_tid = 2; bus.start_pc = 32'h200;
      cyc(); exp_issue("st2", 1, 32'h100);
      bus.start_valid = 0;
      cyc(); exp_issue("rr2", 2, 32'h200);
      cyc(); exp_issue("rr0", 0, 32'h10);
      bus.start_valid = 1; bus.start_tid = 1; bus.start_pc = 32'h800;
      cyc(); exp_issue("rr1", 1, 32'h104);
      bus.start_valid = 0;
      cyc(); exp_issue("rr2b", 2, 32'h204);
      bus.redirect_valid = 1; bus.redirect_tid = 0; bus.redirect_pc = 32'h43;
      cyc(); exp_issue("redir", 0, 32'h40);
      bus.redirect_valid = 0;
      cyc(); exp_issue("ignstart", 1, 32'h108);
      cyc(); exp_issue("rr2c", 2, 32'h208);
      cyc(); exp_issue("postredir", 0, 32'h44);
      bus.stall = 1;
      repeat (3) begin
         cyc(); exp_issue("stall", 0, 32'h44);
      end
      bus.stall = 0;
      cyc(); exp_issue("unstall", 1, 32'h10C);
      bus.block_valid = 1; bus.block_tid = 1;
      cyc(); exp_issue("blk", 2, 32'h20C);
      bus.block_valid = 0; bus.wake_valid = 1; bus.wake_tid = 0;
      cyc(); exp_issue("blk0", 0, 32'h48);
      bus.wake_valid = 0;
      cyc(); exp_issue("blk2", 2, 32'h210);
      cyc(); exp_issue("blk0b", 0, 32'h4C);
      bus.wake_valid = 1; bus.wake_tid = 1;
      cyc(); exp_issue("wake", 2, 32'h214);
      bus.wake_valid = 0;
      cyc(); exp_issue("wake0", 0, 32'h50);
      cyc(); exp_issue("resume1", 1, 32'h110);

      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(499) != 0);
         bus.stall = ($urandom_range(7) == 0);
         bus.start_valid = ($urandom_range(3) == 0);
         bus.start_tid = 3'($urandom_range(N - 1));
         bus.start_pc = ($urandom_range(15) == 0) ? 32'hFFFF_FFF8 : $urandom;
         bus.redirect_valid = ($urandom_range(4) == 0);
         bus.redirect_tid = 3'($urandom_range(N - 1));
         bus.redirect_pc = ($urandom_range(15) == 0) ? 32'hFFFF_FFFF : $urandom;
         bus.block_valid = ($urandom_range(5) == 0);
         bus.block_tid = 3'($urandom_range(N - 1));
         bus.wake_valid = ($urandom_range(2) == 0);
         bus.wake_tid = 3'($urandom_range(N - 1));
         bus.halt_valid = ($urandom_range(9) == 0);
         bus.halt_tid = 3'($urandom_range(N - 1));
         cyc();
      end

      idle_in();
      rst_n = 1'b1;
      for (int t = 0; t < N; t++) begin
         bus.halt_valid = 1; bus.halt_tid = 3'(t);
         cyc();
      end
      bus.halt_valid = 0;
      chk("haltall_valid", {31'b0, bus.fetch_valid}, 32'd0);
      chk("haltall_mask", {24'b0, bus.run_mask}, 32'h0);
`ifdef THREAD_SCHED_FIXED_PRIO_EN
      bus.start_valid = 1; bus.start_tid = 3; bus.start_pc = 32'h300;
      cyc();
      bus.start_tid = 0; bus.start_pc = 32'h0;
      cyc(); exp_issue("fp3", 3, 32'h300);
      bus.start_valid = 0;
      cyc(); exp_issue("fp0a", 0, 32'h0);
      cyc(); exp_issue("fp0b", 0, 32'h4);
      bus.halt_valid = 1; bus.halt_tid = 0;
      cyc(); exp_issue("fphalt", 3, 32'h304);
      bus.halt_valid = 0;
`endif
      cyc();
      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/thread_fetch_sched.md
# thread_fetch_sched

Barrel-style fetch scheduler for the multithreaded RISC-V core. Holds one program counter and one run state per hardware thread, and picks one runnable thread per cycle in round-robin order. It drives the `thread_id`/`pc` address pair into the per-thread instruction memory. It sits at the head of the fetch stage and consumes thread-control events from execute: start, redirect, block, wake and halt.

## Interface
- `NUM_THREADS`, default 8: hardware threads; equals 2^`THREAD_WIDTH`.
- `RESET_PC`, default 32'h0: initial PC of every thread.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: synchronous active-low reset, sampled on `clk`.
- `stall`, input, 1: fetch backpressure; hold the current issue.
- `start_valid`, input, 1: launch an IDLE thread.
- `start_tid` / `start_pc`, input, `THREAD_WIDTH` / `XLEN`: thread to launch and its entry PC.
- `redirect_valid`, input, 1: branch or jump resolved.
- `redirect_tid` / `redirect_pc`, input, `THREAD_WIDTH` / `XLEN`: thread to redirect and its target.
- `block_valid` / `block_tid`, input, 1 / `THREAD_WIDTH`: move a thread to WAIT (e.g. load miss).
- `wake_valid` / `wake_tid`, input, 1 / `THREAD_WIDTH`: return a WAIT thread to RUN.
- `halt_valid` / `halt_tid`, input, 1 / `THREAD_WIDTH`: move a thread to IDLE (ecall/ebreak).
- `fetch_valid`, output, 1: `fetch_tid`/`fetch_pc` hold a live issue.
- `fetch_tid`, output, `THREAD_WIDTH`: goes to imem `thread_id`.
- `fetch_pc`, output, `XLEN`: goes to imem `pc`.
- `run_mask`, output, `NUM_THREADS`: bit i = 1 when thread i is RUN.

## Operation
- Per-thread state is 2 bits: IDLE=0, RUN=1, WAIT=2. Per-thread PC is `XLEN` bits.
- The low two bits of every PC are written as zero: `start_pc`/`redirect_pc` bits [1:0] are ignored.
- Reset values:
  - thread 0: RUN; threads 1..N-1: IDLE.
  - all PCs = `RESET_PC`.
  - round-robin pointer `last` = NUM_THREADS-1.
  - `fetch_valid`=0, `fetch_tid`=0, `fetch_pc`=0, `run_mask`=1.
- Event application, evaluated at each edge:
  - Start: applies only if the target is IDLE; otherwise ignored. Sets state RUN and PC=`start_pc`.
  - Redirect: always loads the thread's PC, whatever its state.
  - Block: applies only to a RUN thread; sets WAIT.
  - Wake: applies only to a WAIT thread; sets RUN.
  - Halt: applies in any state; sets IDLE.
- Same-tid conflicts, in priority order:
  - halt > block > wake > start for state.
  - Redirect and start on the same tid: redirect PC wins.
- Eligibility this cycle: state is RUN now and the thread is not the target of a halt or block this cycle. Threads started or woken this cycle become eligible next cycle.
- Selection when `stall`=0: first eligible tid scanning `last+1, last+2, …` modulo NUM_THREADS.
- On selection, at the edge:
  - `fetch_valid`<=1, `fetch_tid`<=sel, `last`<=sel.
  - `fetch_pc`<=effective PC, where effective PC = `redirect_pc` if a redirect targets sel this cycle (bypass), else the stored PC.
  - PC[sel] <= effective PC + 4, modulo 2^`XLEN` (wraps, no flag).
- No eligible thread and `stall`=0: `fetch_valid`<=0; `fetch_tid`/`fetch_pc` hold; `last` holds.
- `stall`=1:
  - fetch outputs and `last` hold; no PC increment.
  - Events still apply to state and PC.
  - A redirect or halt of the held `fetch_tid` does not alter the held outputs; the pipeline flushes that issue.

## Timing
- Fetch outputs are registered: an issue chosen from state at edge N is visible after edge N until the next non-stalled edge.
- Event-to-fetch latency:
  - Start at edge N: earliest issue at edge N+1.
  - Wake at edge N: earliest issue at edge N+1.
  - Redirect: issue at the same edge when its thread is selected.
- With all 8 threads RUN and no stall, each thread issues exactly every 8 cycles.
- `rst_n`=0 at any edge overrides all events and selection; a stalled issue is discarded.
- `run_mask` is registered and reflects state after the edge.

## Configuration
- `THREAD_SCHED_FIXED_PRIO_EN`:
  - Defined: round-robin is replaced by fixed priority, lowest eligible tid wins every cycle. `last` is still updated but not used.
  - Undefined: round-robin as above.

## Test plan
- Reset, no events: `fetch_pc` 0,4,8,… on tid 0 each cycle; `run_mask`=8'h01.
- Start tids 1 and 2 at 0x100 and 0x200 in cycle 1: issues follow 0,1,2,0,1,2 with PCs 0x100, 0x200, 0x104, …. Repeating start on tid 1 while RUN is ignored.
- 3 threads RUN; block tid 1 for 5 cycles, then wake: issues follow 0,2,0,2,… then 1 resumes at its saved PC. Wake on a non-WAIT thread has no effect.
- Redirect tid 0 to 0x40 in the cycle tid 0 is selected: `fetch_pc`=0x40 and the next tid-0 issue is 0x44. Redirect to 0x43 stores 0x40.
- `stall`=1 for 3 cycles mid-stream: outputs frozen and PCs unchanged; the sequence resumes unchanged. Halt all threads: `fetch_valid`=0 and `run_mask`=0.
- Build with `THREAD_SCHED_FIXED_PRIO_EN` and tids 0 and 3 RUN: only tid 0 issues. Halt tid 0: tid 3 issues next cycle.
